// File: rtl/pos_pid_pkg.sv
// Shared types and constants for the multi-channel position PID controller.
package pos_pid_pkg;

    localparam int unsigned CFG_W  = 24;
    localparam int unsigned GAIN_W = 16;
    localparam int unsigned ISAT_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_MUL  = 3'd2,
        ST_SUM  = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

    localparam logic [2:0] SEL_KP   = 3'd0;
    localparam logic [2:0] SEL_KI   = 3'd1;
    localparam logic [2:0] SEL_KD   = 3'd2;
    localparam logic [2:0] SEL_LIM  = 3'd3;
    localparam logic [2:0] SEL_ISAT = 3'd4;
    localparam logic [2:0] SEL_MODE = 3'd5;

    typedef enum logic [1:0] {
        MODE_PID = 2'd0,
        MODE_PI  = 2'd1,
        MODE_P   = 2'd2,
        MODE_BYP = 2'd3
    } mode_e;

    // Mid-scale code of an offset-binary converter of width dw.
    function automatic int unsigned mid_code(input int unsigned dw);
        return 32'd1 << (dw - 32'd1);
    endfunction

endpackage

// File: rtl/pos_pid_mc_sat_clamp.sv
// Symmetric saturation of a signed value to [-bound, +bound].
module sat_clamp #(
    parameter int unsigned W = 48
) (
    input  logic signed [W-1:0] val,
    input  logic signed [W-1:0] bound,
    output logic signed [W-1:0] val_c,
    output logic                sat_c
);

    // Clamp against the positive then the negative bound.
    always_comb begin
        val_c = val;
        sat_c = 1'b0;
        if (val > bound) begin
            val_c = bound;
            sat_c = 1'b1;
        end else if (val < -bound) begin
            val_c = -bound;
            sat_c = 1'b1;
        end
    end

endmodule

// File: rtl/pos_pid_mc.sv
// Time-multiplexed PID position controller: one shared datapath, per-channel state.
module pos_pid_mc
    import pos_pid_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 48,
    parameter int unsigned KP_SH = 10,
    parameter int unsigned KI_SH = 10,
    parameter int unsigned KD_SH = 8,
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_pid,
    input  logic             sys_rst,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [2:0]       cfg_sel,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CW-1:0]    s_ch,
    input  logic             s_new,
    input  logic [DW-1:0]    s_target,
    input  logic [DW-1:0]    s_adc,
    output logic             m_valid,
    output logic [CW-1:0]    m_ch,
    output logic [DW-1:0]    m_dac,
    output logic             m_sat
);

    localparam logic [DW-1:0] MID     = DW'(mid_code(DW));
    localparam logic [DW-1:0] LIM_MAX = MID - DW'(1);

    state_e               state_q, state_d;
    logic                 s_ready_q, s_ready_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic                 new_q, new_d;
    logic [DW-1:0]        tgt_q, tgt_d;
    logic [DW-1:0]        adc_q, adc_d;
    logic [GAIN_W-1:0]    kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic [DW-1:0]        lim_q, lim_d;
    logic [ISAT_W-1:0]    isat_q, isat_d;
    mode_e                mode_q, mode_d;
    logic signed [AW-1:0] err_q, err_d, derr_q, derr_d;
    logic signed [AW-1:0] p_q, p_d, i_q, i_d, d_q, d_d, pid_q, pid_d;

    logic [GAIN_W-1:0]    ch_kp_q [NCH];
    logic [GAIN_W-1:0]    ch_kp_d [NCH];
    logic [GAIN_W-1:0]    ch_ki_q [NCH];
    logic [GAIN_W-1:0]    ch_ki_d [NCH];
    logic [GAIN_W-1:0]    ch_kd_q [NCH];
    logic [GAIN_W-1:0]    ch_kd_d [NCH];
    logic [DW-1:0]        ch_lim_q [NCH];
    logic [DW-1:0]        ch_lim_d [NCH];
    logic [ISAT_W-1:0]    ch_isat_q [NCH];
    logic [ISAT_W-1:0]    ch_isat_d [NCH];
    mode_e                ch_mode_q [NCH];
    mode_e                ch_mode_d [NCH];
    logic signed [AW-1:0] ch_integ_q [NCH];
    logic signed [AW-1:0] ch_integ_d [NCH];
    logic signed [AW-1:0] ch_elast_q [NCH];
    logic signed [AW-1:0] ch_elast_d [NCH];

    logic                 m_valid_q, m_valid_d;
    logic [CW-1:0]        m_ch_q, m_ch_d;
    logic [DW-1:0]        m_dac_q, m_dac_d;
    logic                 m_sat_q, m_sat_d;

    logic                 cfg_ok_c, s_ok_c;
    logic                 use_i_c, use_d_c, hold_c;
    logic signed [AW-1:0] err_c, elast_c, integ_cur_c, integ_sum_c, integ_clamp_c;
    logic signed [AW-1:0] isat_s_c, lim_s_c, out_clamp_c;
    logic                 integ_hit_c, out_hit_c;

    assign cfg_ok_c = 32'(cfg_ch) < NCH;
    assign s_ok_c   = 32'(s_ch) < NCH;

    assign use_i_c = (mode_q == MODE_PID) || (mode_q == MODE_PI);
    assign use_d_c = (mode_q == MODE_PID);
    assign hold_c  = (mode_q == MODE_P) || (mode_q == MODE_BYP);

    // A new-target sample sees a cleared integrator and last error.
    assign err_c       = $signed(AW'(tgt_q)) - $signed(AW'(adc_q));
    assign elast_c     = new_q ? AW'(0) : ch_elast_q[ch_q];
    assign integ_cur_c = new_q ? AW'(0) : ch_integ_q[ch_q];
    assign integ_sum_c = integ_cur_c + err_q;
    assign isat_s_c    = $signed(AW'(isat_q));
    assign lim_s_c     = $signed(AW'(lim_q));

    sat_clamp #(.W(AW)) u_integ_clamp (
        .val   (integ_sum_c),
        .bound (isat_s_c),
        .val_c (integ_clamp_c),
        .sat_c (integ_hit_c)
    );

    sat_clamp #(.W(AW)) u_out_clamp (
        .val   (pid_q),
        .bound (lim_s_c),
        .val_c (out_clamp_c),
        .sat_c (out_hit_c)
    );

    // Next-state, datapath and per-channel register updates.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        new_d      = new_q;
        tgt_d      = tgt_q;
        adc_d      = adc_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        kd_d       = kd_q;
        lim_d      = lim_q;
        isat_d     = isat_q;
        mode_d     = mode_q;
        err_d      = err_q;
        derr_d     = derr_q;
        p_d        = p_q;
        i_d        = i_q;
        d_d        = d_q;
        pid_d      = pid_q;
        ch_kp_d    = ch_kp_q;
        ch_ki_d    = ch_ki_q;
        ch_kd_d    = ch_kd_q;
        ch_lim_d   = ch_lim_q;
        ch_isat_d  = ch_isat_q;
        ch_mode_d  = ch_mode_q;
        ch_integ_d = ch_integ_q;
        ch_elast_d = ch_elast_q;
        m_valid_d  = 1'b0;
        m_ch_d     = m_ch_q;
        m_dac_d    = m_dac_q;
        m_sat_d    = m_sat_q;

        if (cfg_we && cfg_ok_c) begin
            case (cfg_sel)
                SEL_KP:   ch_kp_d[cfg_ch]   = GAIN_W'(cfg_data);
                SEL_KI:   ch_ki_d[cfg_ch]   = GAIN_W'(cfg_data);
                SEL_KD:   ch_kd_d[cfg_ch]   = GAIN_W'(cfg_data);
                SEL_LIM:  ch_lim_d[cfg_ch]  = DW'(cfg_data);
                SEL_ISAT: ch_isat_d[cfg_ch] = ISAT_W'(cfg_data);
                SEL_MODE: ch_mode_d[cfg_ch] = mode_e'(cfg_data[1:0]);
                default:  ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                // Configuration is snapshotted so later writes cannot disturb this sample.
                if (s_valid && s_ok_c) begin
                    state_d = ST_ERR;
                    ch_d    = s_ch;
                    new_d   = s_new;
                    tgt_d   = s_target;
                    adc_d   = s_adc;
                    kp_d    = ch_kp_q[s_ch];
                    ki_d    = ch_ki_q[s_ch];
                    kd_d    = ch_kd_q[s_ch];
                    lim_d   = (ch_lim_q[s_ch] > LIM_MAX) ? LIM_MAX : ch_lim_q[s_ch];
                    isat_d  = ch_isat_q[s_ch];
                    mode_d  = ch_mode_q[s_ch];
                end
            end
            ST_ERR: begin
                err_d            = err_c;
                derr_d           = err_c - elast_c;
                ch_elast_d[ch_q] = err_c;
                state_d          = ST_MUL;
            end
            ST_MUL: begin
                p_d     = ($signed(AW'(kp_q)) * err_q) >>> KP_SH;
                i_d     = ($signed(AW'(ki_q)) * integ_cur_c) >>> KI_SH;
                d_d     = ($signed(AW'(kd_q)) * derr_q) >>> KD_SH;
                state_d = ST_SUM;
            end
            ST_SUM: begin
                pid_d = p_q + (use_i_c ? i_q : AW'(0)) + (use_d_c ? d_q : AW'(0));
                if (hold_c) begin
                    ch_integ_d[ch_q] = integ_cur_c;
                end else begin
                    ch_integ_d[ch_q] = integ_hit_c ? integ_clamp_c : integ_sum_c;
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                m_valid_d = 1'b1;
                m_ch_d    = ch_q;
                if (mode_q == MODE_BYP) begin
                    m_dac_d = tgt_q;
                    m_sat_d = 1'b0;
                end else begin
                    m_dac_d = DW'($signed(AW'(MID)) + out_clamp_c);
                    m_sat_d = out_hit_c;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_pid) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            s_ready_q  <= 1'b1;
            ch_q       <= '0;
            new_q      <= 1'b0;
            tgt_q      <= '0;
            adc_q      <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            lim_q      <= '0;
            isat_q     <= '0;
            mode_q     <= MODE_PID;
            err_q      <= '0;
            derr_q     <= '0;
            p_q        <= '0;
            i_q        <= '0;
            d_q        <= '0;
            pid_q      <= '0;
            ch_kp_q    <= '{default: '0};
            ch_ki_q    <= '{default: '0};
            ch_kd_q    <= '{default: '0};
            ch_lim_q   <= '{default: '0};
            ch_isat_q  <= '{default: '0};
            ch_mode_q  <= '{default: MODE_PID};
            ch_integ_q <= '{default: '0};
            ch_elast_q <= '{default: '0};
            m_valid_q  <= 1'b0;
            m_ch_q     <= '0;
            m_dac_q    <= MID;
            m_sat_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            ch_q       <= ch_d;
            new_q      <= new_d;
            tgt_q      <= tgt_d;
            adc_q      <= adc_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            kd_q       <= kd_d;
            lim_q      <= lim_d;
            isat_q     <= isat_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            derr_q     <= derr_d;
            p_q        <= p_d;
            i_q        <= i_d;
            d_q        <= d_d;
            pid_q      <= pid_d;
            ch_kp_q    <= ch_kp_d;
            ch_ki_q    <= ch_ki_d;
            ch_kd_q    <= ch_kd_d;
            ch_lim_q   <= ch_lim_d;
            ch_isat_q  <= ch_isat_d;
            ch_mode_q  <= ch_mode_d;
            ch_integ_q <= ch_integ_d;
            ch_elast_q <= ch_elast_d;
            m_valid_q  <= m_valid_d;
            m_ch_q     <= m_ch_d;
            m_dac_q    <= m_dac_d;
            m_sat_q    <= m_sat_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_ch    = m_ch_q;
    assign m_dac   = m_dac_q;
    assign m_sat   = m_sat_q;

endmodule

// File: tb/tb_pos_pid_mc.sv
// Self-checking bench for pos_pid_mc against a per-channel arithmetic model.
module tb_pos_pid_mc;

    localparam int NCH   = 4;
    localparam int CW    = 2;
    localparam int KP_SH = 10;
    localparam int KI_SH = 10;
    localparam int KD_SH = 8;
    localparam longint MIDV = 32768;

    logic          clk_pid = 1'b0;
    logic          sys_rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [2:0]    cfg_sel = '0;
    logic [23:0]   cfg_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [CW-1:0] s_ch = '0;
    logic          s_new = 1'b0;
    logic [15:0]   s_target = '0;
    logic [15:0]   s_adc = '0;
    logic          m_valid;
    logic [CW-1:0] m_ch;
    logic [15:0]   m_dac;
    logic          m_sat;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    longint m_kp [NCH];
    longint m_ki [NCH];
    longint m_kd [NCH];
    longint m_lim [NCH];
    longint m_isat [NCH];
    longint m_mode [NCH];
    longint m_integ [NCH];
    longint m_elast [NCH];
    longint last_dac, last_ch, last_sat;

    pos_pid_mc #(
        .NCH(NCH), .DW(16), .AW(48), .KP_SH(KP_SH), .KI_SH(KI_SH), .KD_SH(KD_SH)
    ) dut (
        .clk_pid  (clk_pid),
        .sys_rst  (sys_rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_ch     (s_ch),
        .s_new    (s_new),
        .s_target (s_target),
        .s_adc    (s_adc),
        .m_valid  (m_valid),
        .m_ch     (m_ch),
        .m_dac    (m_dac),
        .m_sat    (m_sat)
    );

    always #5 clk_pid = ~clk_pid;

    task automatic check(input string tag, input logic [63:0] obs, input longint exp);
        n_checks++;
        assert (obs === 64'(exp)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0; m_lim[c] = 0;
            m_isat[c] = 0; m_mode[c] = 0; m_integ[c] = 0; m_elast[c] = 0;
        end
        last_dac = MIDV; last_ch = 0; last_sat = 0;
    endfunction

    function automatic void model_cfg(input int c, input int s, input int d);
        longint v;
        v = longint'(d) & 64'hFF_FFFF;
        if (c < NCH) begin
            case (s)
                0: m_kp[c]   = v & 64'hFFFF;
                1: m_ki[c]   = v & 64'hFFFF;
                2: m_kd[c]   = v & 64'hFFFF;
                3: m_lim[c]  = v & 64'hFFFF;
                4: m_isat[c] = v;
                5: m_mode[c] = v & 64'h3;
                default: ;
            endcase
        end
    endfunction

    // Expected DAC code and saturation flag; advances the channel's state.
    function automatic void model(input int ch, input int tgt, input int adc, input bit nw,
                                  output longint dac, output bit sat);
        longint err, derr, p, i, d, pid, acc, lim;
        err = longint'(tgt) - longint'(adc);
        if (nw) begin
            m_integ[ch] = 0;
            m_elast[ch] = 0;
        end
        derr = err - m_elast[ch];
        m_elast[ch] = err;
        p = (m_kp[ch] * err) >>> KP_SH;
        i = (m_ki[ch] * m_integ[ch]) >>> KI_SH;
        d = (m_kd[ch] * derr) >>> KD_SH;
        case (m_mode[ch])
            0: pid = p + i + d;
            1: pid = p + i;
            default: pid = p;
        endcase
        if (m_mode[ch] < 2) begin
            acc = m_integ[ch] + err;
            if (acc > m_isat[ch]) acc = m_isat[ch];
            if (acc < -m_isat[ch]) acc = -m_isat[ch];
            m_integ[ch] = acc;
        end
        lim = (m_lim[ch] < MIDV - 1) ? m_lim[ch] : MIDV - 1;
        sat = 1'b0;
        if (pid > lim) begin pid = lim; sat = 1'b1; end
        if (pid < -lim) begin pid = -lim; sat = 1'b1; end
        dac = MIDV + pid;
        if (m_mode[ch] == 3) begin
            dac = tgt;
            sat = 1'b0;
        end
    endfunction

    task automatic cfg_write(input int c, input int s, input int d);
        cfg_we = 1'b1; cfg_ch = CW'(c); cfg_sel = 3'(s); cfg_data = 24'(d);
        @(negedge clk_pid);
        cfg_we = 1'b0;
        model_cfg(c, s, d);
    endtask

    // One sample: checks ready, 4-cycle latency, one-cycle m_valid, held outputs, result.
    task automatic send(input int ch, input int tgt, input int adc, input bit nw,
                        input bit mid_cfg, input int cc, input int cs, input int cd,
                        output longint o_dac, output bit o_sat);
        longint e_dac;
        bit     e_sat;
        int     n;
        model(ch, tgt, adc, nw, e_dac, e_sat);
        n = 0;
        while (s_ready !== 1'b1 && n < 10) begin
            @(negedge clk_pid);
            n++;
        end
        check("s_ready_before_accept", 64'(s_ready), 1);
        s_valid = 1'b1; s_ch = CW'(ch); s_new = nw;
        s_target = 16'(tgt); s_adc = 16'(adc);
        @(negedge clk_pid);
        s_valid = 1'b0; s_new = 1'b0;
        o_dac = 0; o_sat = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk_pid);
            if (mid_cfg && k == 1) begin
                cfg_we = 1'b1; cfg_ch = CW'(cc); cfg_sel = 3'(cs); cfg_data = 24'(cd);
            end
            if (mid_cfg && k == 2) begin
                cfg_we = 1'b0;
                model_cfg(cc, cs, cd);
            end
            check("s_ready_busy", 64'(s_ready), (k == 4) ? 1 : 0);
            check("m_valid_timing", 64'(m_valid), (k == 4) ? 1 : 0);
            if (k < 4) begin
                check("m_dac_hold", 64'(m_dac), last_dac);
            end else begin
                check("m_dac", 64'(m_dac), e_dac);
                check("m_ch", 64'(m_ch), ch);
                check("m_sat", 64'(m_sat), longint'(e_sat));
                o_dac = longint'(m_dac);
                o_sat = m_sat;
            end
        end
        last_dac = e_dac; last_ch = ch; last_sat = longint'(e_sat);
    endtask

    initial begin
        longint od;
        bit     os;
        int     tg, ad, ch;

        model_reset();
        @(negedge clk_pid);
        @(negedge clk_pid);
        check("rst_s_ready", 64'(s_ready), 1);
        check("rst_m_valid", 64'(m_valid), 0);
        check("rst_m_dac", 64'(m_dac), MIDV);
        check("rst_m_ch", 64'(m_ch), 0);
        check("rst_m_sat", 64'(m_sat), 0);
        sys_rst = 1'b0;
        @(negedge clk_pid);

        // Proportional only, inside the limit.
        cfg_write(0, 0, 1024);
        cfg_write(0, 3, 1000);
        send(0, 33000, 32768, 1'b1, 1'b0, 0, 0, 0, od, os);
        check("p_basic_dac", 64'(od), 33000);
        check("p_basic_sat", 64'(os), 0);

        // Output clamp in both directions.
        cfg_write(1, 0, 1024);
        cfg_write(1, 3, 100);
        send(1, 40000, 32768, 1'b1, 1'b0, 0, 0, 0, od, os);
        check("clamp_hi_dac", 64'(od), 32868);
        check("clamp_hi_sat", 64'(os), 1);
        send(1, 32768, 40000, 1'b0, 1'b0, 0, 0, 0, od, os);
        check("clamp_lo_dac", 64'(od), 32668);
        check("clamp_lo_sat", 64'(os), 1);

        // Integrator saturation at -i_sat, seen through the I term.
        cfg_write(2, 1, 1024);
        cfg_write(2, 4, 500);
        cfg_write(2, 3, 1000);
        send(2, 32468, 32768, 1'b1, 1'b0, 0, 0, 0, od, os);
        check("integ_s1", 64'(od), 32768);
        send(2, 32468, 32768, 1'b0, 1'b0, 0, 0, 0, od, os);
        check("integ_s2", 64'(od), 32468);
        send(2, 32468, 32768, 1'b0, 1'b0, 0, 0, 0, od, os);
        check("integ_s3", 64'(od), 32268);
        send(2, 32468, 32768, 1'b0, 1'b0, 0, 0, 0, od, os);
        check("integ_s4", 64'(od), 32268);

        // Back-to-back interleaving of two channels with full PID.
        cfg_write(3, 0, 512);  cfg_write(3, 1, 256); cfg_write(3, 2, 128);
        cfg_write(3, 4, 1000); cfg_write(3, 3, 2000);
        cfg_write(0, 1, 512);  cfg_write(0, 2, 256); cfg_write(0, 4, 800);
        for (int j = 0; j < 10; j++) begin
            tg = 32768 + int'($urandom_range(0, 2000)) - 1000;
            ad = 32768 + int'($urandom_range(0, 2000)) - 1000;
            send((j % 2 == 0) ? 0 : 3, tg, ad, 1'b0, 1'b0, 0, 0, 0, od, os);
        end

        // Bypass holds the integrator; a new target then clears it.
        cfg_write(1, 1, 1024);
        cfg_write(1, 4, 50);
        send(1, 32800, 32768, 1'b0, 1'b0, 0, 0, 0, od, os);
        check("pre_bypass_dac", 64'(od), 32800);
        cfg_write(1, 5, 3);
        send(1, 12345, 32768, 1'b0, 1'b0, 0, 0, 0, od, os);
        check("bypass_dac", 64'(od), 12345);
        check("bypass_sat", 64'(os), 0);
        cfg_write(1, 5, 0);
        send(1, 32800, 32768, 1'b1, 1'b0, 0, 0, 0, od, os);
        check("new_clears_integ", 64'(od), 32800);

        // A write during a computation only affects the following sample.
        send(0, 33000, 32768, 1'b1, 1'b1, 0, 0, 0, od, os);
        send(0, 33000, 32768, 1'b0, 1'b0, 0, 0, 0, od, os);
        cfg_write(0, 6, 4321);
        cfg_write(0, 7, 99);
        send(0, 32000, 32768, 1'b0, 1'b0, 0, 0, 0, od, os);

        // Reset while the sample is in MUL.
        s_valid = 1'b1; s_ch = CW'(0); s_new = 1'b0; s_target = 16'(34000); s_adc = 16'(32768);
        @(negedge clk_pid);
        s_valid = 1'b0;
        @(negedge clk_pid);
        sys_rst = 1'b1;
        @(negedge clk_pid);
        sys_rst = 1'b0;
        model_reset();
        check("rst_mid_s_ready", 64'(s_ready), 1);
        for (int k = 0; k < 6; k++) begin
            check("rst_mid_no_valid", 64'(m_valid), 0);
            check("rst_mid_dac", 64'(m_dac), MIDV);
            @(negedge clk_pid);
        end
        send(0, 33000, 32768, 1'b0, 1'b0, 0, 0, 0, od, os);
        check("post_rst_first", 64'(od), MIDV);

        // Randomized configuration and traffic.
        for (int j = 0; j < 10; j++) begin
            int s, d;
            s = int'($urandom_range(0, 7));
            case (s)
                0, 1, 2: d = int'($urandom_range(0, 4095));
                3:       d = int'($urandom_range(0, 40000));
                4:       d = int'($urandom_range(0, 1 << 20));
                5:       d = int'($urandom_range(0, 3));
                default: d = int'($urandom);
            endcase
            cfg_write(int'($urandom_range(0, NCH - 1)), s, d);
        end
        for (int j = 0; j < 40; j++) begin
            bit mc;
            ch = int'($urandom_range(0, NCH - 1));
            if ($urandom_range(0, 1) == 0) begin
                tg = 32768 + int'($urandom_range(0, 6000)) - 3000;
                ad = 32768 + int'($urandom_range(0, 6000)) - 3000;
            end else begin
                tg = int'($urandom_range(0, 65535));
                ad = int'($urandom_range(0, 65535));
            end
            mc = ($urandom_range(0, 3) == 0);
            send(ch, tg, ad, ($urandom_range(0, 4) == 0), mc,
                 int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 3000)), od, os);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
